iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
Multi-cycle, sequential counterpart of the combinational 16-bit barrel shifter. It performs the same four shift/rotate operations, but applies one log2 stage per clock: shift by 8, then 4, then 2, then 1. It sits beside the ALU as a shared, area-reduced shift unit and uses a start/busy/done handshake. It is intended for the pipelined core, where the single-cycle barrel path is too slow.

Parameters:
- WIDTH, 16, data width in bits. Must be a power of two.
- CNTW, 4, shift-count width. Must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when busy=0.
- In  input  WIDTH  operand to be shifted.
- Cnt  input  CNTW  shift amount, 0..WIDTH-1.
- Op  input  2  operation select. Op[1]=0 is left, Op[1]=1 is right:
  - 00 ROL (rotate left)
  - 01 SLL (shift left logical, zero fill)
  - 10 ROR (rotate right)
  - 11 SRL (shift right logical, zero fill)
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; Out is valid for the new result.
- Out  output  WIDTH  registered result. Held until the next done.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: busy=0, done=0, Out=0, state=IDLE, internal data/count/op/stage registers=0.
- State machine has two states, IDLE and RUN.
  - IDLE: busy=0. If start=1 at a clk edge:
    - latch In→acc, Cnt→cnt_r, Op→op_r;
    - set stage index k=CNTW-1;
    - go to RUN.
    If start=0, remain in IDLE.
  - RUN: busy=1. At each edge, stage k is applied:
    - if cnt_r[k]=1, acc ← acc shifted or rotated by 2^k per op_r; otherwise acc is unchanged.
    - If k>0: decrement k and stay in RUN.
    - If k=0: Out ← the stage-0 result, done=1 for exactly one cycle, go to IDLE.
- Latency: with start sampled at edge t, done=1 and Out is valid after edge t+CNTW (4 cycles for the defaults). Latency is fixed and independent of Cnt.
- Shift rules per stage of 2^k:
  - ROL: acc = {acc[W-1-2^k:0], acc[W-1:W-2^k]}.
  - ROR: the mirror of ROL.
  - SLL: shift left, zero fill into the LSBs.
  - SRL: shift right, zero fill into the MSBs.
- Composing the stages gives the total shift Cnt.
  - Cnt=0 → Out=In.
  - Rotates wrap modulo WIDTH.
- Boundary conditions:
  - start while busy=1: ignored, with no effect on the operation in flight. There is no queueing.
  - start in the cycle where done=1: accepted, because busy=0 in that cycle. Back-to-back operations therefore complete every CNTW+1 cycles.
  - In/Cnt/Op changing while in RUN: no effect, because the operands were latched at start.
  - rst asserted mid-operation: the operation is abandoned and all outputs return to their reset values immediately. No done is produced for the abandoned operation.
  - Out changes only at the edge that raises done, or on reset.

Test Plan:
- Reset, then ROL: hold rst=1 and check busy=0, done=0, Out=0. Release rst. Apply start with Op=00, In=0x8001, Cnt=1. Required: done after exactly 4 edges and Out=0x0003; busy high for those 4 cycles.
- SLL and ROR: Op=01, In=0x00FF, Cnt=4 → Out=0x0FF0. Then Op=10, In=0x0001, Cnt=15 → Out=0x0002.
- SRL and Cnt=0: Op=11, In=0x8000, Cnt=15 → Out=0x0001. Then Op=11, In=0xBEEF, Cnt=0 → Out=0xBEEF, still at 4-cycle latency.
- Start while busy: start ROL 0x1234 by 4. Pulse start with In=0xFFFF, Op=11, Cnt=8 during RUN. Required: a single done with Out=0x2341; the second request is ignored and busy drops after done.
- Back-to-back: assert start in the done cycle with SLL 0x0001 by 15. Required: second done 5 cycles after the first, Out=0x8000, and the first result is held between the two done pulses.
- Reset mid-operation: start SRL 0xF000 by 4, then assert rst after 2 edges. Required: busy, done and Out go to 0 immediately. No done appears after rst release until a new start.

Source files
------------

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shift/rotate unit, one log2 stage per clock
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNTW-1:0]  Cnt,
    input  logic [1:0]       Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    localparam int KW = (CNTW > 1) ? $clog2(CNTW) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(CNTW - 1);
    localparam logic [CNTW:0]   WFULL  = (CNTW + 1)'(WIDTH);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  acc, acc_n;
    logic [CNTW-1:0]   cnt_r, cnt_n;
    logic [1:0]        op_r, op_n;
    logic [KW-1:0]     k, k_n;
    logic [WIDTH-1:0]  out_n;
    logic              done_n;

    logic [CNTW:0]     amt;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  stage_res;

    // Stage k moves acc by 2^k; the stage is skipped when that count bit is clear.
    always_comb begin
        amt = (CNTW + 1)'(1) << k;
        case (op_r)
            OP_ROL:  shifted = (acc << amt) | (acc >> (WFULL - amt));
            OP_SLL:  shifted = acc << amt;
            OP_ROR:  shifted = (acc >> amt) | (acc << (WFULL - amt));
            default: shifted = acc >> amt;
        endcase
        stage_res = cnt_r[k] ? shifted : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt_r <= '0;
            op_r  <= '0;
            k     <= '0;
            Out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt_r <= cnt_n;
            op_r  <= op_n;
            k     <= k_n;
            Out   <= out_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt_r;
        op_n    = op_r;
        k_n     = k;
        out_n   = Out;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = In;
                    cnt_n   = Cnt;
                    op_n    = Op;
                    k_n     = K_LAST;
                    state_n = RUN;
                end
            end
            default: begin
                acc_n = stage_res;
                if (k == '0) begin
                    out_n   = stage_res;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    k_n = k - 1'b1;
                end
            end
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_d = '0;
    logic [3:0]  cnt_d = '0;
    logic [1:0]  op_d = '0;
    logic        busy;
    logic        done;
    logic [15:0] out_d;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] held = '0;

    iter_shifter #(.WIDTH(16), .CNTW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (in_d),
        .Cnt   (cnt_d),
        .Op    (op_d),
        .busy  (busy),
        .done  (done),
        .Out   (out_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is raised here and done must follow exactly 4 edges later.
    task automatic run_op(input logic [1:0] op, input logic [15:0] din,
                          input logic [3:0] c, input logic [15:0] exp, input string tag);
        op_d  = op;
        in_d  = din;
        cnt_d = c;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done"}, 32'(done), 32'd0);
            check({tag, " hold"}, 32'(out_d), 32'(held));
        end
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " out"}, 32'(out_d), 32'(exp));
        held = exp;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst out", 32'(out_d), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        run_op(2'b00, 16'h8001, 4'd1, 16'h0003, "rol");
        @(negedge clk);
        run_op(2'b01, 16'h00FF, 4'd4, 16'h0FF0, "sll");
        @(negedge clk);
        run_op(2'b10, 16'h0001, 4'd15, 16'h0002, "ror15");
        @(negedge clk);
        run_op(2'b11, 16'h8000, 4'd15, 16'h0001, "srl15");
        @(negedge clk);
        run_op(2'b11, 16'hBEEF, 4'd0, 16'hBEEF, "cnt0");
        @(negedge clk);

        // second start during RUN with different operands must be ignored
        op_d  = 2'b00;
        in_d  = 16'h1234;
        cnt_d = 4'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_d  = 16'hFFFF;
        op_d  = 2'b11;
        cnt_d = 4'd8;
        check("busy_ign busy1", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("busy_ign busy2", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_ign busy3", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_ign early_done", 32'(done), 32'd0);
        @(negedge clk);
        check("busy_ign done", 32'(done), 32'd1);
        check("busy_ign out", 32'(out_d), 32'h2341);
        held = 16'h2341;
        @(negedge clk);
        check("busy_ign no_second_done", 32'(done), 32'd0);
        check("busy_ign busy_low", 32'(busy), 32'd0);
        check("busy_ign held", 32'(out_d), 32'h2341);

        run_op(2'b11, 16'hBEEF, 4'd4, 16'h0BEE, "b2b_first");
        run_op(2'b01, 16'h0001, 4'd15, 16'h8000, "b2b_second");
        @(negedge clk);

        // reset two edges into an operation
        op_d  = 2'b11;
        in_d  = 16'hF000;
        cnt_d = 4'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst out", 32'(out_d), 32'd0);
        held = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst done", 32'(done), 32'd0);
            check("postrst busy", 32'(busy), 32'd0);
        end
        check("postrst out", 32'(out_d), 32'd0);

        run_op(2'b10, 16'h0001, 4'd1, 16'h8000, "recover");
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
